// File: rtl/scan_pkg.sv
// rtl/scan_pkg.sv - state encoding and widths shared by the digit scan controller
package scan_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    SHOW  = 2'd2
  } scan_state_t;

  localparam int SEL_W   = 3;
  localparam int DIGIT_W = 4;
  // Wide enough for a slot length of up to 65535 cycles.
  localparam int CNT_W   = 16;

endpackage

// File: rtl/scan_prescaler.sv
// rtl/scan_prescaler.sv - slot prescaler counting 0..DIV-1, held at 0 while clr is high
module scan_prescaler
  import scan_pkg::*;
#(
  parameter int DIV = 1000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  output logic             tc,
  output logic [CNT_W-1:0] count
);

  assign tc = (count == CNT_W'(DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr || tc) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/digit_scan_ctrl.sv
// rtl/digit_scan_ctrl.sv - multiplexed digit scanner; SCAN_BLANK_EN adds per-slot blanking
module digit_scan_ctrl
  import scan_pkg::*;
#(
  parameter int DIV          = 1000,
  parameter int NUM_DIGITS   = 8,
  parameter int BLANK_CYCLES = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               run,
  input  logic [31:0]        digits,
  input  logic [7:0]         blink_mask,
  input  logic               blink_phase,
  output logic [SEL_W-1:0]   sel,
  output logic               enable,
  output logic [DIGIT_W-1:0] digit_out,
  output logic               frame_start
);

`ifdef SCAN_BLANK_EN
  localparam bit BLANK_ON = 1'b1;
`else
  localparam bit BLANK_ON = 1'b0;
`endif

  scan_state_t      state;
  logic             clr;
  logic             tc;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] nxt_count;
  logic [SEL_W-1:0] nxt_sel;
  logic             nxt_blank;
  logic             nxt_frame;

  // Prescaler is held at 0 while stopped so the first running cycle is slot position 0.
  assign clr = !run || (state == IDLE);

  scan_prescaler #(
    .DIV (DIV)
  ) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .tc    (tc),
    .count (count)
  );

  // Outputs are registered, so everything is decided from the slot position of the next cycle.
  always_comb begin
    nxt_count = tc ? '0 : count + 1'b1;
    nxt_sel   = sel;
    nxt_frame = 1'b0;
    if (!run || (state == IDLE)) begin
      nxt_count = '0;
      nxt_sel   = '0;
      nxt_frame = (state == IDLE);
    end else if (tc) begin
      nxt_sel   = (sel == SEL_W'(NUM_DIGITS - 1)) ? '0 : sel + 1'b1;
      nxt_frame = (nxt_sel == '0);
    end
    nxt_blank = BLANK_ON && (nxt_count < CNT_W'(BLANK_CYCLES));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      sel         <= '0;
      enable      <= 1'b0;
      digit_out   <= '0;
      frame_start <= 1'b0;
    end else begin
      sel       <= nxt_sel;
      digit_out <= digits[{nxt_sel, 2'b00} +: DIGIT_W];
      if (!run) begin
        state       <= IDLE;
        enable      <= 1'b0;
        frame_start <= 1'b0;
      end else begin
        state       <= nxt_blank ? BLANK : SHOW;
        enable      <= !nxt_blank && !(blink_mask[nxt_sel] && blink_phase);
        frame_start <= nxt_frame;
      end
    end
  end

endmodule

// File: tb/tb_digit_scan_ctrl.sv
// tb/tb_digit_scan_ctrl.sv - directed bench for digit_scan_ctrl (6-digit and 1-digit instances)
module tb_digit_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        run;
  logic [31:0] digits;
  logic [7:0]  blink_mask;
  logic        blink_phase;

  logic [2:0]  sel,  sel1;
  logic        enable, enable1;
  logic [3:0]  digit_out, digit_out1;
  logic        frame_start, frame_start1;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  digit_scan_ctrl #(.DIV(4), .NUM_DIGITS(6), .BLANK_CYCLES(1)) u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .run         (run),
    .digits      (digits),
    .blink_mask  (blink_mask),
    .blink_phase (blink_phase),
    .sel         (sel),
    .enable      (enable),
    .digit_out   (digit_out),
    .frame_start (frame_start)
  );

  digit_scan_ctrl #(.DIV(3), .NUM_DIGITS(1), .BLANK_CYCLES(1)) u_one (
    .clk         (clk),
    .rst_n       (rst_n),
    .run         (run),
    .digits      (digits),
    .blink_mask  (blink_mask),
    .blink_phase (blink_phase),
    .sel         (sel1),
    .enable      (enable1),
    .digit_out   (digit_out1),
    .frame_start (frame_start1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_stopped(input string tag);
    chk({tag, "_sel"}, 32'(sel), 32'd0);
    chk({tag, "_enable"}, 32'(enable), 32'd0);
    chk({tag, "_frame"}, 32'(frame_start), 32'd0);
    chk({tag, "_sel1"}, 32'(sel1), 32'd0);
    chk({tag, "_enable1"}, 32'(enable1), 32'd0);
  endtask

  // i = cycles since the scan left IDLE; slot 0 position 0 is i=0.
  task automatic chk_pos(input int i);
    int   s;
    int   c;
    int   c1;
    logic e;
    logic e1;
    s  = (i / 4) % 6;
    c  = i % 4;
    c1 = i % 3;
    e  = 1'b1;
    e1 = 1'b1;
`ifdef SCAN_BLANK_EN
    if (c == 0) e = 1'b0;
    if (c1 == 0) e1 = 1'b0;
`endif
    if (blink_mask[s] && blink_phase) e = 1'b0;
    chk("sel", 32'(sel), 32'(s));
    chk("enable", 32'(enable), 32'(e));
    chk("digit_out", 32'(digit_out), 32'(s + 1));
    chk("frame_start", 32'(frame_start), 32'((i % 24) == 0));
    chk("sel1", 32'(sel1), 32'd0);
    chk("enable1", 32'(enable1), 32'(e1));
    chk("digit_out1", 32'(digit_out1), 32'd1);
    chk("frame_start1", 32'(frame_start1), 32'((i % 3) == 0));
  endtask

  initial begin
    rst_n       = 1'b0;
    run         = 1'b0;
    digits      = 32'h8765_4321;
    blink_mask  = 8'h00;
    blink_phase = 1'b0;

    #2;
    chk_stopped("reset");
    chk("reset_digit_out", 32'(digit_out), 32'd0);
    step();
    step();
    chk_stopped("reset_held");
    chk("reset_held_digit_out", 32'(digit_out), 32'd0);

    #2 rst_n = 1'b1;
    step();
    chk_stopped("idle");
    chk("idle_digit_out", 32'(digit_out), 32'd1);

    run = 1'b1;
    for (int i = 0; i < 24; i++) begin
      step();
      chk_pos(i);
    end

    blink_mask  = 8'h04;
    blink_phase = 1'b1;
    for (int i = 24; i < 48; i++) begin
      step();
      chk_pos(i);
    end

    blink_phase = 1'b0;
    for (int i = 48; i < 62; i++) begin
      step();
      chk_pos(i);
    end

    // Sitting in slot 3 here; dropping run must return to digit 0 unlit.
    run = 1'b0;
    step();
    chk_stopped("stop");
    chk("stop_digit_out", 32'(digit_out), 32'd1);
    step();
    chk_stopped("stop_idle");

    run = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk_pos(i);
    end

    #2 rst_n = 1'b0;
    #1;
    chk_stopped("async_reset");
    chk("async_reset_digit_out", 32'(digit_out), 32'd0);
    chk("async_reset_digit_out1", 32'(digit_out1), 32'd0);
    #2 rst_n = 1'b1;
    for (int i = 0; i < 30; i++) begin
      step();
      chk_pos(i);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
